ram_1wnr: RTL and testbench
===========================

Name: ram_1wnr

Overview:
- Parametrised synthesizable RAM for the CPU core: one byte-masked write port and N_RD independent read ports (port 0 = IF, port 1 = LSU by convention).
- Replaces DPI-helper memory with an internal register array.
- Reads are registered: 1-cycle latency, valid flag, per-port stall.
- Addresses are physical, rebased by BASE_ADDR; out-of-range accesses are flagged rather than aliased.

Parameters:
- DATA_W, 64, word width in bits; power of two, at least 16.
- ADDR_W, 64, address width.
- DEPTH_LOG2, 12, log2 of word count (4096 words = 32 KiB).
- N_RD, 2, number of read ports, 1..4.
- BASE_ADDR, 64'h8000_0000, physical address of word 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write byte address.
- wr_data  in  DATA_W  write data, lane-aligned to the word.
- wr_strb  in  DATA_W/8  byte enables; bit k covers bits [8k+7:8k].
- wr_err  out  1  registered pulse: previous-cycle write was out of range.
- rd_en  in  N_RD  per-port read request.
- rd_addr  in  N_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_stall  in  N_RD  per-port consumer stall.
- rd_valid  out  N_RD  read data valid.
- rd_data  out  N_RD*DATA_W  packed read data.
- rd_err  out  N_RD  accompanies rd_valid: address out of range.

Behaviour:
- Index computation: idx = (addr - BASE_ADDR) >> log2(DATA_W/8).
  - Low byte-offset bits are ignored; no misalignment trap.
  - In range iff addr >= BASE_ADDR and idx < 2**DEPTH_LOG2. Compare on the full-width subtraction, never a truncated index.
- Reset (async assert, sync release):
  - rd_valid = 0, rd_data = 0, rd_err = 0, wr_err = 0.
  - Array contents are NOT reset.
  - While rst = 1, writes are suppressed and reads are not accepted.
  - Reset mid-read: the pending result is dropped; rd_valid stays 0 after release until a new request.
- Write:
  - If wr_en and in range at edge T, bytes with wr_strb = 1 are updated at T; others are untouched.
  - wr_strb = 0 is a legal no-op.
  - Out-of-range write: array is untouched; wr_err = 1 for the cycle after T only.
- Read, port i, per edge:
  - If rd_stall[i] = 1 and rd_valid[i] = 1: hold rd_valid, rd_data and rd_err unchanged; rd_en[i] is ignored (request dropped; requester must re-present).
  - Else if rd_en[i] = 1: rd_valid = 1, rd_data = mem[idx] (or 0 if out of range), rd_err = !in_range.
  - Else: rd_valid = 0, rd_data holds its last value, rd_err = 0.
  - rd_stall with rd_valid = 0 has no effect; the request is accepted.
  - Latency: data is valid on the edge after acceptance; back-to-back reads run at 1 per cycle per port.
- Ports are independent. Multiple ports reading the same index in the same cycle all receive the same data.
- Same-edge read/write collision (same idx, both in range): see Optional Feature.

Optional Feature:
- Macro: RAM_RD_BYPASS_EN.
- Defined (write-first): a read accepted at the same edge as a write to the same idx returns the merged word, with new bytes where wr_strb = 1 and old bytes elsewhere.
- Undefined (read-first): that read returns the pre-write word; the following read sees the new data.
- Non-colliding behaviour is identical in both builds.

Decomposition:
- Shared package ram_pkg:
  - STRB_W = DATA_W/8.
  - OFF_W = log2(STRB_W).
  - Function strb_to_mask(strb) → DATA_W bit mask.
  - Function addr_to_idx(addr, base) returning {in_range, idx}.
- One natural sub-module, ram_rd_port: the per-port output register, stall/hold logic, out-of-range zeroing and bypass merge. Generated N_RD times around the shared array.

Test Plan:
- Reset then read: rst pulse mid-run with rd_en = 1 → rd_valid = 0, rd_data = 0 through release; the first read after release has 1-cycle latency.
- Byte-masked write: write 64'h1122334455667788 to 0x8000_0010 with strb 8'hFF, then 64'hAAAA_AAAA_AAAA_AAAA with strb 8'h0F; read 0x8000_0010 → 64'h11223344AAAAAAAA, rd_err = 0.
- Out of range:
  - Write to 0x7FFF_FFF8 → wr_err high exactly 1 cycle, array unchanged.
  - Read 0x8000_8000 (idx 4096) → rd_valid = 1, rd_err = 1, rd_data = 0.
- Collision: write 64'hDEAD_BEEF_0000_0001 (strb 8'hFF) and read the same address at the same edge.
  - Bypass build → DEAD_BEEF_0000_0001.
  - Non-bypass build → old value; next read → new value.
- Stall: port 1 reads 0x8000_0000 and 0x8000_0008 back-to-back with rd_stall[1] = 1 in cycle 2.
  - First data held for the stall cycle; the second request is dropped.
  - Port 0 is unaffected in parallel.
- Multi-port: N_RD = 3, all ports read distinct addresses each cycle for 100 random cycles with random writes → every result matches the reference model.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for ram_1wnr: strobe-to-mask expansion and the
// rebased, range-checked address-to-index translation.
package ram_pkg;

    localparam int DEF_DATA_W     = 64;
    localparam int DEF_ADDR_W     = 64;
    localparam int DEF_DEPTH_LOG2 = 12;
    localparam int DEF_N_RD       = 2;
    localparam logic [63:0] DEF_BASE_ADDR = 64'h8000_0000;

    localparam int STRB_W = DEF_DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    // Helpers work at maximum width; callers zero-extend inputs and slice results.
    localparam int MAX_ADDR_W = 64;
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    typedef struct packed {
        logic                  in_range;
        logic [MAX_ADDR_W-1:0] idx;
    } idx_res_t;

    function automatic logic [MAX_DATA_W-1:0] strb_to_mask(input logic [MAX_STRB_W-1:0] strb);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_STRB_W; k++) m[8*k +: 8] = {8{strb[k]}};
        return m;
    endfunction

    // Range test uses the full-width difference so nothing below the base or
    // past the end can alias back into the array.
    function automatic idx_res_t addr_to_idx(input logic [MAX_ADDR_W-1:0] addr,
                                             input logic [MAX_ADDR_W-1:0] base,
                                             input int off_w, input int depth_log2);
        idx_res_t r;
        logic [MAX_ADDR_W-1:0] diff;
        diff       = addr - base;
        r.idx      = diff >> off_w;
        r.in_range = (addr >= base) && (r.idx < (64'd1 << depth_log2));
        return r;
    endfunction

endpackage

// File: rtl/ram_rd_port.sv
// One registered read port: stall hold, out-of-range zeroing and, when
// RAM_RD_BYPASS_EN is defined, write-first merge of a same-edge write.
module ram_rd_port #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              stall,
    input  logic              in_range,
    input  logic [DATA_W-1:0] word,
    input  logic              wr_hit,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [DATA_W-1:0] rd_word;

`ifdef RAM_RD_BYPASS_EN
    always_comb begin
        rd_word = word;
        if (wr_hit) rd_word = (word & ~wr_mask) | (wr_data & wr_mask);
    end
`else
    logic unused_ok;
    assign unused_ok = ^{wr_hit, wr_data, wr_mask};
    always_comb rd_word = word;
`endif

    // A stalled, still-valid result is frozen and any new request is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            err   <= 1'b0;
        end else if (!(stall && valid)) begin
            if (en) begin
                valid <= 1'b1;
                data  <= in_range ? rd_word : '0;
                err   <= !in_range;
            end else begin
                valid <= 1'b0;
                err   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ram_1wnr.sv
// Byte-masked single-write, N_RD-read RAM with registered reads and range
// flags. Define RAM_RD_BYPASS_EN for write-first same-index collisions.
module ram_1wnr
    import ram_pkg::*;
#(
    parameter int          DATA_W     = DEF_DATA_W,
    parameter int          ADDR_W     = DEF_ADDR_W,
    parameter int          DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int          N_RD       = DEF_N_RD,
    parameter logic [63:0] BASE_ADDR  = DEF_BASE_ADDR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_strb,
    output logic                     wr_err,
    input  logic [N_RD-1:0]          rd_en,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    input  logic [N_RD-1:0]          rd_stall,
    output logic [N_RD-1:0]          rd_valid,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    idx_res_t                         wres;
    idx_res_t [N_RD-1:0]              rres;
    logic [MAX_STRB_W-1:0]            strb_full;
    logic [MAX_DATA_W-1:0]            mask_full;
    logic [DATA_W-1:0]                wr_mask;
    logic [DEPTH_LOG2-1:0]            wr_idx;
    logic                             wr_ok;
    logic [N_RD-1:0][DEPTH_LOG2-1:0]  rd_idx;
    logic [N_RD-1:0]                  rd_in;
    logic [N_RD-1:0][DATA_W-1:0]      rd_word;
    logic [N_RD-1:0]                  rd_hit;

    always_comb begin
        logic [63:0] a;
        a = '0;
        a[ADDR_W-1:0] = wr_addr;
        wres = addr_to_idx(a, BASE_ADDR, OFFS, DEPTH_LOG2);
        strb_full = '0;
        strb_full[BYTES-1:0] = wr_strb;
        mask_full = strb_to_mask(strb_full);
    end

    assign wr_mask = mask_full[DATA_W-1:0];
    assign wr_idx  = wres.idx[DEPTH_LOG2-1:0];
    assign wr_ok   = wr_en && wres.in_range && !rst;

    always_comb begin
        logic [63:0] a;
        rres   = '0;
        rd_idx = '0;
        rd_in  = '0;
        for (int i = 0; i < N_RD; i++) begin
            a = '0;
            a[ADDR_W-1:0] = rd_addr[i*ADDR_W +: ADDR_W];
            rres[i]   = addr_to_idx(a, BASE_ADDR, OFFS, DEPTH_LOG2);
            rd_idx[i] = rres[i].idx[DEPTH_LOG2-1:0];
            rd_in[i]  = rres[i].in_range;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{wres, rres, mask_full};

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_err <= 1'b0;
        else     wr_err <= wr_en && !wres.in_range;
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        assign rd_word[i] = mem[rd_idx[i]];
        assign rd_hit[i]  = wr_ok && rd_in[i] && (wr_idx == rd_idx[i]);

        ram_rd_port #(.DATA_W(DATA_W)) u_port (
            .clk      (clk),
            .rst      (rst),
            .en       (rd_en[i]),
            .stall    (rd_stall[i]),
            .in_range (rd_in[i]),
            .word     (rd_word[i]),
            .wr_hit   (rd_hit[i]),
            .wr_data  (wr_data),
            .wr_mask  (wr_mask),
            .valid    (rd_valid[i]),
            .data     (rd_data[i*DATA_W +: DATA_W]),
            .err      (rd_err[i])
        );
    end

endmodule

// File: tb/tb_ram_1wnr.sv
// Directed table plus hand-written corner sequences and a model-checked
// random phase for ram_1wnr with three read ports.
module tb_ram_1wnr;

    localparam int N = 3;
    localparam logic [63:0] B = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                wr_en;
    logic [63:0]         wr_addr;
    logic [63:0]         wr_data;
    logic [7:0]          wr_strb;
    logic                wr_err;
    logic [N-1:0]        rd_en, rd_stall, rd_valid, rd_err;
    logic [N-1:0][63:0]  rd_addr, rd_data;

    ram_1wnr #(.DATA_W(64), .ADDR_W(64), .DEPTH_LOG2(12), .N_RD(N), .BASE_ADDR(B)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(wr_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_stall(rd_stall),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        rd_en = '0; rd_stall = '0; rd_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [63:0] wa, wd;
        logic [7:0]  ws;
        logic        re;
        logic [63:0] ra;
        logic        ev;
        logic [63:0] ed;
        logic        ee, ewe;
    } vec_t;

    vec_t tbl [10];

    logic [63:0] mdl [32];
    logic [N-1:0]       mv, me;
    logic [N-1:0][63:0] md;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, B+64'h10, 64'h1122334455667788, 8'hFF, 1'b0, 64'h0,       1'b0, 64'h0,                 1'b0, 1'b0};
        tbl[1] = '{1'b1, B+64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 64'h0,       1'b0, 64'h0,                 1'b0, 1'b0};
        tbl[2] = '{1'b1, B+64'h7FF8, 64'h0123456789ABCDEF, 8'hFF, 1'b1, B+64'h10,  1'b1, 64'h11223344AAAAAAAA,  1'b0, 1'b0};
        tbl[3] = '{1'b1, 64'h7FFF_FFF8, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, B+64'h14, 1'b1, 64'h11223344AAAAAAAA, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 64'h0,    64'h0,                8'h00, 1'b0, 64'h0,       1'b0, 64'h11223344AAAAAAAA,  1'b0, 1'b0};
        tbl[5] = '{1'b0, 64'h0,    64'h0,                8'h00, 1'b1, B+64'h7FF8, 1'b1, 64'h0123456789ABCDEF,  1'b0, 1'b0};
        tbl[6] = '{1'b0, 64'h0,    64'h0,                8'h00, 1'b1, B+64'h8000, 1'b1, 64'h0,                 1'b1, 1'b0};
        tbl[7] = '{1'b1, B+64'h10, 64'h5555555555555555, 8'h00, 1'b0, 64'h0,       1'b0, 64'h0,                 1'b0, 1'b0};
        tbl[8] = '{1'b0, 64'h0,    64'h0,                8'h00, 1'b1, B+64'h10,   1'b1, 64'h11223344AAAAAAAA,  1'b0, 1'b0};
        tbl[9] = '{1'b0, 64'h0,    64'h0,                8'h00, 1'b1, 64'h7FFF_FFF8, 1'b1, 64'h0,              1'b1, 1'b0};

        // reset state
        idle_in();
        rst = 1'b1;
        step(); step();
        chk("reset rd_valid", 64'(rd_valid), 64'h0);
        chk("reset rd_err",   64'(rd_err),   64'h0);
        chk("reset wr_err",   64'(wr_err),   64'h0);
        chk("reset rd_data",  rd_data[0] | rd_data[1] | rd_data[2], 64'h0);
        rst = 1'b0;
        step();

        // directed table on port 0
        for (int i = 0; i < 10; i++) begin
            idle_in();
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; wr_strb = tbl[i].ws;
            rd_en[0] = tbl[i].re; rd_addr[0] = tbl[i].ra;
            step();
            chk($sformatf("vec%0d rd_valid", i), 64'(rd_valid[0]), 64'(tbl[i].ev));
            chk($sformatf("vec%0d rd_data",  i), rd_data[0],        tbl[i].ed);
            chk($sformatf("vec%0d rd_err",   i), 64'(rd_err[0]),   64'(tbl[i].ee));
            chk($sformatf("vec%0d wr_err",   i), 64'(wr_err),      64'(tbl[i].ewe));
        end

        // stall on port 1 with port 0 running alongside
        idle_in();
        wr_en = 1; wr_strb = 8'hFF; wr_addr = B;        wr_data = 64'h0000_0000_CAFE_0000; step();
        wr_addr = B + 64'h8; wr_data = 64'h1111_2222_3333_4444; step();
        idle_in();
        rd_en = 3'b011; rd_addr[1] = B; rd_addr[0] = B + 64'h8;
        step();
        chk("stall c1 p1 valid", 64'(rd_valid[1]), 64'h1);
        chk("stall c1 p1 data",  rd_data[1], 64'h0000_0000_CAFE_0000);
        chk("stall c1 p0 data",  rd_data[0], 64'h1111_2222_3333_4444);
        rd_addr[1] = B + 64'h8; rd_stall[1] = 1'b1; rd_addr[0] = B;
        step();
        chk("stall c2 p1 valid", 64'(rd_valid[1]), 64'h1);
        chk("stall c2 p1 data",  rd_data[1], 64'h0000_0000_CAFE_0000);
        chk("stall c2 p0 data",  rd_data[0], 64'h0000_0000_CAFE_0000);
        rd_en = '0; rd_stall = '0;
        step();
        chk("stall c3 p1 valid (dropped)", 64'(rd_valid[1]), 64'h0);
        chk("stall c3 p1 data held",       rd_data[1], 64'h0000_0000_CAFE_0000);
        chk("stall c3 p0 valid",           64'(rd_valid[0]), 64'h0);

        // reset in the middle of reading, with a write suppressed during reset
        idle_in();
        wr_en = 1; wr_strb = 8'hFF; wr_addr = B + 64'h18; wr_data = 64'h77; step();
        wr_addr = 64'h7FFF_FFF8; rd_en[0] = 1; rd_addr[0] = B + 64'h10;
        step();
        chk("pre-rst rd_data", rd_data[0], 64'h11223344AAAAAAAA);
        chk("pre-rst wr_err",  64'(wr_err), 64'h1);
        rst = 1'b1; wr_addr = B + 64'h18; wr_data = 64'h99;
        #1;
        chk("rst async rd_valid", 64'(rd_valid[0]), 64'h0);
        chk("rst async rd_data",  rd_data[0], 64'h0);
        chk("rst async wr_err",   64'(wr_err), 64'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("in-rst rd_valid", 64'(rd_valid[0]), 64'h0);
            chk("in-rst rd_data",  rd_data[0], 64'h0);
        end
        rst = 1'b0; wr_en = 0; rd_en = '0;
        step();
        chk("post-rst idle rd_valid", 64'(rd_valid[0]), 64'h0);
        rd_en[0] = 1; rd_addr[0] = B + 64'h18;
        step();
        chk("post-rst read valid", 64'(rd_valid[0]), 64'h1);
        chk("post-rst read data",  rd_data[0], 64'h77);

        // same-edge write/read collision
        idle_in();
        wr_en = 1; wr_strb = 8'hFF; wr_addr = B + 64'h10; wr_data = 64'hDEAD_BEEF_0000_0001;
        rd_en[0] = 1; rd_addr[0] = B + 64'h10;
        step();
`ifdef RAM_RD_BYPASS_EN
        chk("collision read", rd_data[0], 64'hDEAD_BEEF_0000_0001);
`else
        chk("collision read", rd_data[0], 64'h11223344AAAAAAAA);
`endif
        wr_en = 0;
        step();
        chk("post-collision read", rd_data[0], 64'hDEAD_BEEF_0000_0001);

        // random multi-port phase against a small model over words 0..31
        idle_in();
        for (int k = 0; k < 32; k++) begin
            wr_en = 1; wr_strb = 8'hFF; wr_addr = B + 64'(k*8);
            wr_data = {$urandom, $urandom};
            mdl[k] = wr_data;
            step();
        end
        idle_in();
        for (int it = 0; it < 100; it++) begin
            int wi;
            logic woor, whit;
            logic [63:0] mask, merged;
            wi     = $urandom_range(0, 31);
            woor   = ($urandom_range(0, 7) == 0);
            wr_en  = $urandom_range(0, 1);
            wr_strb = 8'($urandom);
            wr_data = {$urandom, $urandom};
            wr_addr = woor ? B - 64'(8*(wi+1)) : B + 64'(wi*8 + $urandom_range(0, 7));
            for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{wr_strb[b]}};
            merged = (mdl[wi] & ~mask) | (wr_data & mask);
            whit   = wr_en && !woor;
            for (int p = 0; p < N; p++) begin
                int ri;
                logic roor;
                ri   = $urandom_range(0, 31);
                roor = (it != 0) && ($urandom_range(0, 7) == 0);
                rd_en[p]    = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                rd_stall[p] = (it != 0) && ($urandom_range(0, 3) == 0);
                rd_addr[p]  = roor ? B + 64'h8000 + 64'(ri*8) : B + 64'(ri*8 + $urandom_range(0, 7));
                if (rd_stall[p] && mv[p]) begin
                    // result frozen
                end else if (rd_en[p]) begin
                    mv[p] = 1'b1;
                    me[p] = roor;
                    if (roor) md[p] = '0;
`ifdef RAM_RD_BYPASS_EN
                    else if (whit && wi == ri) md[p] = merged;
`endif
                    else md[p] = mdl[ri];
                end else begin
                    mv[p] = 1'b0;
                    me[p] = 1'b0;
                end
            end
            if (whit) mdl[wi] = merged;
            step();
            for (int p = 0; p < N; p++) begin
                chk($sformatf("rand%0d p%0d rd_valid", it, p), 64'(rd_valid[p]), 64'(mv[p]));
                chk($sformatf("rand%0d p%0d rd_data",  it, p), rd_data[p], md[p]);
                chk($sformatf("rand%0d p%0d rd_err",   it, p), 64'(rd_err[p]), 64'(me[p]));
            end
            chk($sformatf("rand%0d wr_err", it), 64'(wr_err), 64'(wr_en && woor));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
